// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the single-wire serial data path. The transmitter
// (serial_pattern_tx) and the sequence detectors on the receiving end both
// use the state encoding and the frame-length helper.
//
// Contents:
//   state_t    : ST_IDLE / ST_SHIFT transmitter states
//   frame_len  : number of bit periods per frame (data bits + optional parity)
// ---------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit periods in one frame: WIDTH data bits, plus one when parity is on.
  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

endpackage : serial_pkg

// File: rtl/bit_clk_div.sv
// ---------------------------------------------------------------------------
// bit_clk_div
// Bit-period divider for the serial transmitter. Counts DIV system clocks per
// serial bit and produces the registered bit clock and bit strobe.
//
// Parameters:
//   DIV      clock cycles per serial bit (even, >= 2)
//
// Ports:
//   clock    in   system clock, rising edge
//   clear    in   asynchronous active-low reset
//   start    in   begin a new bit period at the next edge (div_cnt -> 0)
//   en       in   advance within the current bit period
//   clk1     out  registered bit clock, high for the first DIV/2 cycles
//   bit_stb  out  registered one-cycle pulse in the first cycle of a period
//   tc       out  terminal count: last cycle of the current bit period
//
// With neither start nor en asserted the divider parks at 0 with clk1 low.
// The counter never wraps on its own; the owner restarts it with start.
// ---------------------------------------------------------------------------
module bit_clk_div #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic en,
  output logic clk1,
  output logic bit_stb,
  output logic tc
);

  localparam int DCW = $clog2(DIV);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [DCW-1:0] DIV_HALF = DCW'(DIV / 2);

  logic [DCW-1:0] div_cnt;
  logic [DCW-1:0] div_inc;

  assign tc      = (div_cnt == DIV_LAST);
  assign div_inc = div_cnt + DCW'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      div_cnt <= '0;
      clk1    <= 1'b0;
      bit_stb <= 1'b0;
    end else if (start) begin
      div_cnt <= '0;
      clk1    <= 1'b1;
      bit_stb <= 1'b1;
    end else if (en && !tc) begin
      // clk1 is registered, so it is decoded from the value div_cnt is about
      // to take rather than the current one.
      div_cnt <= div_inc;
      clk1    <= (div_inc < DIV_HALF);
      bit_stb <= 1'b0;
    end else begin
      div_cnt <= '0;
      clk1    <= 1'b0;
      bit_stb <= 1'b0;
    end
  end

endmodule : bit_clk_div

// File: rtl/serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// serial_pattern_tx
// Serial bit-stream transmitter feeding a detector's dI input. Accepts a
// parallel word via load/ready, shifts it out MSB-first with DIV clocks per
// bit, and optionally recirculates the word with no gap between frames.
//
// Parameters:
//   WIDTH     data bits per frame (2..32)
//   DIV       clock cycles per serial bit (even, >= 2)
//   IDLE_LVL  level on dO when not transmitting
//
// Ports:
//   clock    in   system clock, all state on rising edge
//   clear    in   asynchronous active-low reset
//   load     in   word valid; accepted when load && ready at a rising edge
//   din      in   parallel word, captured on acceptance
//   rep      in   1 = recirculate captured word, 0 = one-shot (sampled at
//                 frame end only)
//   dO       out  serial data, MSB first
//   clk1     out  bit clock, high for first DIV/2 cycles of each bit
//   bit_stb  out  pulse in the first cycle of every bit period
//   ready    out  high in IDLE
//   busy     out  high in SHIFT
//   done     out  one-cycle pulse after the last bit period of a frame
//
// Build option:
//   SERIAL_TX_PARITY_EN  appends an even-parity bit (XOR of the data bits)
//                        after the LSB; frame becomes (WIDTH+1)*DIV cycles.
// ---------------------------------------------------------------------------
module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   DIV      = 4,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             rep,
  output logic             dO,
  output logic             clk1,
  output logic             bit_stb,
  output logic             ready,
  output logic             busy,
  output logic             done
);

`ifdef SERIAL_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int NBITS = frame_len(WIDTH, PAR_EN);
  localparam int BCW   = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(NBITS - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [WIDTH-1:0] shadow, shadow_d;
  logic [BCW-1:0]   bit_cnt, bit_cnt_d;
  logic             dout_d;
  logic             done_d;
  logic             div_start;
  logic             div_en;
  logic             div_tc;
  logic             next_bit;

  bit_clk_div #(
    .DIV (DIV)
  ) u_div (
    .clock   (clock),
    .clear   (clear),
    .start   (div_start),
    .en      (div_en),
    .clk1    (clk1),
    .bit_stb (bit_stb),
    .tc      (div_tc)
  );

  // Bit that follows the current one: the next data bit out of the shift
  // register, or the parity bit once the LSB period ends.
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [BCW-1:0] LAST_DATA = BCW'(WIDTH - 1);
  logic parity;
  assign parity   = ^shadow;
  assign next_bit = (bit_cnt == LAST_DATA) ? parity : shreg[WIDTH-2];
`else
  assign next_bit = shreg[WIDTH-2];
`endif

  assign ready = (state == ST_IDLE);
  assign busy  = (state == ST_SHIFT);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      shadow  <= '0;
      bit_cnt <= '0;
      dO      <= IDLE_LVL;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      shadow  <= shadow_d;
      bit_cnt <= bit_cnt_d;
      dO      <= dout_d;
      done    <= done_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state;
    shreg_d   = shreg;
    shadow_d  = shadow;
    bit_cnt_d = bit_cnt;
    dout_d    = dO;
    done_d    = 1'b0;
    div_start = 1'b0;
    div_en    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        dout_d = IDLE_LVL;
        if (load) begin
          shreg_d   = din;
          shadow_d  = din;
          dout_d    = din[WIDTH-1];
          bit_cnt_d = '0;
          div_start = 1'b1;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (!div_tc) begin
          div_en = 1'b1;
        end else if (bit_cnt != LAST_BIT) begin
          shreg_d   = shreg << 1;
          dout_d    = next_bit;
          bit_cnt_d = bit_cnt + BCW'(1);
          div_start = 1'b1;
        end else begin
          // Frame end: rep is only looked at here, so dropping it mid-frame
          // lets the current frame finish.
          done_d    = 1'b1;
          bit_cnt_d = '0;
          if (rep) begin
            shreg_d   = shadow;
            dout_d    = shadow[WIDTH-1];
            div_start = 1'b1;
          end else begin
            dout_d  = IDLE_LVL;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule : serial_pattern_tx

// File: tb/tb_serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_pattern_tx
// Self-checking bench for serial_pattern_tx (WIDTH=8, DIV=4, IDLE_LVL=1).
// A cycle model pushes the expected {dO, clk1, bit_stb, ready, busy, done}
// for every clock into a queue as stimulus is applied; each cycle the DUT
// outputs are sampled on the falling edge and compared against the head.
// Honours SERIAL_TX_PARITY_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_serial_pattern_tx;
  import serial_pkg::*;

  localparam int WIDTH = 8;
  localparam int DIV   = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB    = frame_len(WIDTH, PAR);
  localparam int FRAME = NB * DIV;

  typedef struct packed {
    logic d;
    logic c1;
    logic stb;
    logic rdy;
    logic bsy;
    logic dn;
  } obs_t;

  typedef struct {
    logic [WIDTH-1:0] din;
    logic             par;   // expected even-parity bit of din
  } vec_t;

  logic             clock = 1'b0;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             rep;
  logic             dO, clk1, bit_stb, ready, busy, done;

  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t sb[$];
  bit   pend_done = 1'b0;

  localparam obs_t IDLE_OBS = '{d: 1'b1, c1: 1'b0, stb: 1'b0, rdy: 1'b1, bsy: 1'b0, dn: 1'b0};

  serial_pattern_tx #(
    .WIDTH    (WIDTH),
    .DIV      (DIV),
    .IDLE_LVL (1'b1)
  ) dut (
    .clock   (clock),
    .clear   (clear),
    .load    (load),
    .din     (din),
    .rep     (rep),
    .dO      (dO),
    .clk1    (clk1),
    .bit_stb (bit_stb),
    .ready   (ready),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  function automatic obs_t sample();
    obs_t o;
    o = {dO, clk1, bit_stb, ready, busy, done};
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got dO/clk1/stb/rdy/busy/done=%b required %b",
               name, $time, got, exp);
    end
  endtask

  // Expected cycles of one frame; the first cycle carries the done pulse of
  // a preceding frame when recirculating.
  task automatic push_frame(input logic [WIDTH-1:0] w, input logic p);
    obs_t o;
    logic b;
    for (int i = 0; i < NB; i++) begin
      b = (i < WIDTH) ? w[WIDTH-1-i] : p;
      for (int c = 0; c < DIV; c++) begin
        o = '{d: b, c1: (c < DIV/2), stb: (c == 0), rdy: 1'b0, bsy: 1'b1,
              dn: (i == 0 && c == 0) ? pend_done : 1'b0};
        sb.push_back(o);
      end
      pend_done = 1'b0;
    end
    pend_done = 1'b1;
  endtask

  task automatic push_idle(input int n);
    obs_t o;
    for (int k = 0; k < n; k++) begin
      o    = IDLE_OBS;
      o.dn = pend_done;
      pend_done = 1'b0;
      sb.push_back(o);
    end
  endtask

  // Advance n cycles; load is a single-cycle request so it drops after the
  // first edge. Each falling edge pops and compares one expected cycle.
  task automatic run_cycles(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      load = 1'b0;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: scoreboard empty, got %b required <nothing>", name, sample());
      end else begin
        check(name, sample(), sb.pop_front());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by %0t required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{din: 8'hA5, par: 1'b0};
    vecs[1] = '{din: 8'h07, par: 1'b1};
    vecs[2] = '{din: 8'h3C, par: 1'b0};
    vecs[3] = '{din: 8'h01, par: 1'b1};
    vecs[4] = '{din: 8'h80, par: 1'b1};
    vecs[5] = '{din: 8'hFF, par: 1'b0};

    clear = 1'b0;
    load  = 1'b0;
    din   = '0;
    rep   = 1'b0;

    // Reset, then idle with load low.
    repeat (2) @(negedge clock);
    check("reset", sample(), IDLE_OBS);
    clear = 1'b1;
    push_idle(20);
    run_cycles(20, "idle");

    // One-shot frames, back to back with the minimum single idle cycle.
    foreach (vecs[v]) begin
      load = 1'b1;
      din  = vecs[v].din;
      push_frame(vecs[v].din, vecs[v].par);
      push_idle(1);
      run_cycles(FRAME + 1, $sformatf("oneshot_%h", vecs[v].din));
    end
    push_idle(2);
    run_cycles(2, "idle_after_oneshot");

    // Recirculate 0F; drop rep at bit 3 of the third frame.
    load = 1'b1;
    din  = 8'h0F;
    rep  = 1'b1;
    push_frame(8'h0F, 1'b0);
    push_frame(8'h0F, 1'b0);
    push_frame(8'h0F, 1'b0);
    push_idle(1);
    run_cycles(2 * FRAME + 3 * DIV, "repeat");
    rep = 1'b0;
    run_cycles(FRAME - 3 * DIV + 1, "repeat_tail");
    push_idle(3);
    run_cycles(3, "repeat_idle");

    // Load while busy is ignored.
    load = 1'b1;
    din  = 8'h00;
    push_frame(8'h00, 1'b0);
    push_idle(1);
    run_cycles(10, "busy_load");
    load = 1'b1;
    din  = 8'hFF;
    run_cycles(FRAME + 1 - 10, "busy_load");
    push_idle(2);
    run_cycles(2, "busy_load_idle");

    // Asynchronous reset mid-frame.
    load = 1'b1;
    din  = 8'hC3;
    push_frame(8'hC3, 1'b0);
    run_cycles(12, "abort_pre");
    @(posedge clock);
    #2 clear = 1'b0;
    #1 check("abort_async", sample(), IDLE_OBS);
    sb.delete();
    pend_done = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    push_idle(8);
    run_cycles(8, "post_abort");

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d leftover required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_serial_pattern_tx

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Serial bit-stream transmitter: the driving end of the single-wire serial data path the team's sequence detectors consume on their dI input. It accepts a parallel word through a valid/ready handshake and shifts it out MSB-first, one bit per DIV clocks. It also outputs the matching divided bit clock clk1 and a frame-done pulse. It sits between stimulus/control logic and a detector's serial input, and can recirculate a pattern continuously.

Parameters:
WIDTH, 8, data bits per frame (2..32)
DIV, 4, clock cycles per serial bit (even, >=2)
IDLE_LVL, 1, level driven on dO when not transmitting

Ports:
clock  in  1  system clock, all state on rising edge
clear  in  1  asynchronous, active-low reset
load  in  1  word valid; accepted when load && ready at a rising edge
din  in  WIDTH  parallel word, captured on acceptance
rep  in  1  1 = recirculate the captured word continuously; 0 = one-shot
dO  out  1  serial data, MSB first
clk1  out  1  bit clock, high for the first DIV/2 cycles of each bit period
bit_stb  out  1  one-cycle pulse in the first cycle of every bit period
ready  out  1  high only in IDLE
busy  out  1  high in SHIFT
done  out  1  one-cycle pulse after the last bit period of a frame

Behaviour:
- Reset (clear low, asynchronous): state=IDLE, dO=IDLE_LVL, clk1=0, bit_stb=0, done=0, busy=0, ready=1. Shift register, bit counter and divider all 0.
- States: IDLE, SHIFT. All outputs are registered.
- IDLE: ready=1, dO=IDLE_LVL. On load=1 at edge N: capture din into the shift register and a shadow register, go to SHIFT. From edge N: dO=din[WIDTH-1], bit_stb=1, clk1=1, div_cnt=0, bit_cnt=0.
- SHIFT: div_cnt increments every cycle. clk1=1 while div_cnt<DIV/2. At div_cnt==DIV-1:
  - if bit_cnt<WIDTH-1: shift left, dO takes the next bit, bit_cnt++, div_cnt=0, bit_stb pulses.
  - if bit_cnt==WIDTH-1 (frame end): done pulses for the next cycle. rep is sampled at this edge only.
    - rep=1: reload from the shadow register with no idle gap; dO=MSB, bit_stb pulses.
    - rep=0: return to IDLE; dO=IDLE_LVL, ready=1 in the same cycle that done is high.
- Latency: first bit is valid the cycle after acceptance. A frame is WIDTH*DIV cycles. Back-to-back one-shot frames have exactly 1 idle cycle minimum between them (the accept edge).
- load while busy: ignored, no queuing. din changes during SHIFT: no effect.
- rep deasserted mid-frame: the current frame completes, then the block returns to IDLE.
- Reset mid-frame: immediate abort to reset values; no done pulse.
- bit_cnt width: clog2(WIDTH+1). div_cnt width: clog2(DIV). Counters never wrap past their terminal values.

Optional Feature:
SERIAL_TX_PARITY_EN
- Defined: one even-parity bit (XOR of all WIDTH data bits) is appended after the LSB as an extra bit period. Frame length becomes (WIDTH+1)*DIV. done is issued after the parity bit.
- Undefined: no parity bit, and no parity logic is synthesized.

Decomposition:
- Shared package serial_pkg: state encoding constants (ST_IDLE, ST_SHIFT) and a frame_len function of WIDTH and the parity option. The detector side reuses both.
- Natural sub-module: bit_clk_div (div_cnt, clk1, bit_stb, terminal-count flag), parameterised by DIV. The shift/FSM logic stays in the top module.

Test Plan:
- Reset then idle: clear low for 2 cycles, then high with load=0 for 20 cycles -> dO=1, ready=1, busy=0, done never pulses.
- One-shot, WIDTH=8, DIV=4: load=1 with din=8'hA5 for one cycle -> dO=1,0,1,0,0,1,0,1, each bit held 4 cycles. bit_stb has 8 pulses spaced 4 apart. done pulses at cycle 32 after accept, then dO=1 and ready=1.
- Repeat mode: rep=1, load 8'h0F -> pattern 00001111 repeats with no gap and done every 32 cycles. Drop rep at bit 3 of the 3rd frame -> the 3rd frame completes, then IDLE.
- Load while busy: load 8'hFF at cycle 10 of an 8'h00 frame -> ignored; output stays all-zero for the full 32 cycles.
- Reset mid-frame: clear low at cycle 13 of an 8'hC3 frame -> dO=1, busy=0, clk1=0 immediately (asynchronously); no done pulse.
- With SERIAL_TX_PARITY_EN defined: load 8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1 (parity=1), done at cycle 36.
